pkt_egress_scheduler: RTL and testbench

- Packet-granular round-robin scheduler that drains up to pNUM_PORTS packet-buffer instances (per-port RAM plus length FIFO) onto one byte-wide transmit stream.
- Sits between the per-port receive buffers and the single TX MAC/PCS.
- Sequences each buffer's length pop and byte reads, muxes read data, generates dv/last framing, enforces an inter-frame gap, and discards packets with illegal lengths.

---
 rtl/pkt_egress_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_pkt_egress_scheduler.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_egress_scheduler.sv
// Packet-granular round-robin egress scheduler: drains per-port packet buffers onto one byte stream.
// Optional statistics counters are enabled with the PKT_EGRESS_STATS_EN macro.
module pkt_egress_scheduler #(
   parameter int pNUM_PORTS         = 4,
   parameter int pDATA_WIDTH        = 8,
   parameter int pMIN_PACKET_LENGHT = 64,
   parameter int pMAX_PACKET_LENGHT = 1536,
   parameter int pLEN_WIDTH         = $clog2(pMAX_PACKET_LENGHT) + 1,
   parameter int pIFG_CYCLES        = 12
) (
   input  logic                              iclk,
   input  logic                              i_rst,
   input  logic [pNUM_PORTS-1:0]             ipkt_avail,
   input  logic [pNUM_PORTS*pLEN_WIDTH-1:0]  ilen,
   input  logic [pNUM_PORTS*pDATA_WIDTH-1:0] ird_data,
   output logic [pNUM_PORTS-1:0]             olen_pop,
   output logic [pNUM_PORTS-1:0]             ord_en,
   output logic                              otx_dv,
   output logic [pDATA_WIDTH-1:0]            otx_d,
   output logic                              otx_last,
   output logic [$clog2(pNUM_PORTS)-1:0]     otx_port,
   output logic                              obusy,
   output logic                              olen_err,
   output logic [1:0]                        odbg_state
`ifdef PKT_EGRESS_STATS_EN
   ,
   output logic [31:0]                       otx_pkt_cnt,
   output logic [15:0]                       odrop_cnt
`endif
);

   localparam int lpPORT_W = $clog2(pNUM_PORTS);
   localparam int lpGAP_W  = $clog2(pIFG_CYCLES + 2);
   localparam logic [pLEN_WIDTH-1:0] lpMIN_LEN = pLEN_WIDTH'(pMIN_PACKET_LENGHT);
   localparam logic [pLEN_WIDTH-1:0] lpMAX_LEN = pLEN_WIDTH'(pMAX_PACKET_LENGHT);
   localparam logic [pLEN_WIDTH-1:0] lpLEN_ONE = pLEN_WIDTH'(1);
   // The extra gap cycle after READ covers the byte still in the output register.
   localparam logic [lpGAP_W-1:0]    lpGAP_TX   = lpGAP_W'(pIFG_CYCLES + 1);
   localparam logic [lpGAP_W-1:0]    lpGAP_ZERO = lpGAP_W'(pIFG_CYCLES);
   localparam logic [lpGAP_W-1:0]    lpGAP_ONE  = lpGAP_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_READ  = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [lpPORT_W-1:0]     port_q, port_d;
   logic [lpPORT_W-1:0]     last_q, last_d;
   logic [pLEN_WIDTH-1:0]   cnt_q, cnt_d;
   logic [lpGAP_W-1:0]      gap_q, gap_d;
   logic                    discard_q, discard_d;
   logic                    tx_dv_q, tx_dv_d;
   logic                    tx_last_q, tx_last_d;

   logic [lpPORT_W-1:0]     winner;
   logic [lpPORT_W-1:0]     arb_sel;
   logic [pLEN_WIDTH-1:0]   head_len;
   logic                    len_legal;

   // Rotating priority: the lowest offset above the last grant wins.
   always_comb begin
      winner  = last_q;
      arb_sel = '0;
      for (int i = pNUM_PORTS; i >= 1; i--) begin
         arb_sel = lpPORT_W'((int'(last_q) + i) % pNUM_PORTS);
         if (ipkt_avail[arb_sel]) begin
            winner = arb_sel;
         end
      end
   end

   assign head_len  = ilen[int'(port_q)*pLEN_WIDTH +: pLEN_WIDTH];
   assign len_legal = (head_len >= lpMIN_LEN) && (head_len <= lpMAX_LEN);

   always_comb begin
      state_d   = state_q;
      port_d    = port_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      gap_d     = gap_q;
      discard_d = discard_q;
      olen_pop  = '0;
      ord_en    = '0;
      olen_err  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|ipkt_avail) begin
               state_d = ST_GRANT;
               port_d  = winner;
               last_d  = winner;
            end
         end
         ST_GRANT: begin
            olen_pop[port_q] = 1'b1;
            cnt_d            = head_len;
            discard_d        = ~len_legal;
            olen_err         = ~len_legal;
            if (head_len == '0) begin
               gap_d   = lpGAP_ZERO;
               state_d = ST_GAP;
            end else begin
               state_d = ST_READ;
            end
         end
         ST_READ: begin
            ord_en[port_q] = 1'b1;
            if (cnt_q != '0) begin
               cnt_d = cnt_q - lpLEN_ONE;
            end
            if (cnt_q == lpLEN_ONE) begin
               gap_d   = lpGAP_TX;
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (gap_q <= lpGAP_ONE) begin
               gap_d   = '0;
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q - lpGAP_ONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign tx_dv_d   = (state_q == ST_READ) && !discard_q;
   assign tx_last_d = (state_q == ST_READ) && (cnt_q == lpLEN_ONE) && !discard_q;

   always_ff @(posedge iclk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         port_q    <= '0;
         last_q    <= lpPORT_W'(pNUM_PORTS - 1);
         cnt_q     <= '0;
         gap_q     <= '0;
         discard_q <= 1'b0;
         tx_dv_q   <= 1'b0;
         tx_last_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         port_q    <= port_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         gap_q     <= gap_d;
         discard_q <= discard_d;
         tx_dv_q   <= tx_dv_d;
         tx_last_q <= tx_last_d;
      end
   end

   // RAM data arrives one cycle after ord_en, aligned with the registered dv.
   assign otx_d      = tx_dv_q ? ird_data[int'(port_q)*pDATA_WIDTH +: pDATA_WIDTH] : '0;
   assign otx_dv     = tx_dv_q;
   assign otx_last   = tx_last_q;
   assign otx_port   = port_q;
   assign obusy      = (state_q != ST_IDLE);
   assign odbg_state = state_q;

`ifdef PKT_EGRESS_STATS_EN
   logic [31:0] pkt_cnt_q, pkt_cnt_d;
   logic [15:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      pkt_cnt_d  = pkt_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (tx_last_q) begin
         pkt_cnt_d = pkt_cnt_q + 32'd1;
      end
      if (olen_err && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge iclk or posedge i_rst) begin
      if (i_rst) begin
         pkt_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         pkt_cnt_q  <= pkt_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign otx_pkt_cnt = pkt_cnt_q;
   assign odrop_cnt   = drop_cnt_q;
`else
   // Statistics counters are absent in this build.
`endif

endmodule

// File: tb/tb_pkt_egress_scheduler.sv
// Directed testbench for pkt_egress_scheduler: buffer model, negedge monitor, asserted checks.
module tb_pkt_egress_scheduler;
   localparam int N   = 4;
   localparam int DW  = 8;
   localparam int LW  = 12;
   localparam int PW  = 2;
   localparam int IFG = 12;

   logic            iclk = 1'b0;
   logic            i_rst = 1'b1;
   logic [N-1:0]    ipkt_avail;
   logic [N*LW-1:0] ilen;
   logic [N*DW-1:0] ird_data = '0;
   logic [N-1:0]    olen_pop;
   logic [N-1:0]    ord_en;
   logic            otx_dv;
   logic [DW-1:0]   otx_d;
   logic            otx_last;
   logic [PW-1:0]   otx_port;
   logic            obusy;
   logic            olen_err;
   logic [1:0]      odbg_state;
`ifdef PKT_EGRESS_STATS_EN
   logic [31:0]     otx_pkt_cnt;
   logic [15:0]     odrop_cnt;
`endif

   pkt_egress_scheduler dut (
      .iclk       (iclk),
      .i_rst      (i_rst),
      .ipkt_avail (ipkt_avail),
      .ilen       (ilen),
      .ird_data   (ird_data),
      .olen_pop   (olen_pop),
      .ord_en     (ord_en),
      .otx_dv     (otx_dv),
      .otx_d      (otx_d),
      .otx_last   (otx_last),
      .otx_port   (otx_port),
      .obusy      (obusy),
      .olen_err   (olen_err),
      .odbg_state (odbg_state)
`ifdef PKT_EGRESS_STATS_EN
      ,
      .otx_pkt_cnt(otx_pkt_cnt),
      .odrop_cnt  (odrop_cnt)
`endif
   );

   // Clock and cycle counter
   always #5 iclk = ~iclk;
   int cyc = 0;
   always @(posedge iclk) cyc <= cyc + 1;

   // Buffer model: length FIFO per port plus a byte RAM with a read pointer
   logic [LW-1:0] len_mem [N][16] = '{default: '0};
   int wr_idx [N] = '{default: 0};
   int rd_idx [N] = '{default: 0};
   int rd_ptr [N] = '{default: 0};
   int data_addr [N] = '{default: 0};

   function automatic logic [DW-1:0] byte_of(input int k, input int p);
      return DW'((k * 37 + p * 5 + 3) & 255);
   endfunction

   always_comb begin
      for (int k = 0; k < N; k++) begin
         ipkt_avail[k]       = (wr_idx[k] != rd_idx[k]);
         ilen[k*LW +: LW]    = len_mem[k][rd_idx[k] % 16];
      end
   end

   always @(posedge iclk) begin
      for (int k = 0; k < N; k++) begin
         if (olen_pop[k]) rd_idx[k] <= rd_idx[k] + 1;
         if (ord_en[k]) begin
            ird_data[k*DW +: DW] <= byte_of(k, rd_ptr[k]);
            data_addr[k]         <= rd_ptr[k];
            rd_ptr[k]            <= rd_ptr[k] + 1;
         end
      end
   end

   // Monitor, sampled on the falling edge
   int dv_cnt = 0, last_cnt = 0, err_cnt = 0;
   int pop_cnt [N] = '{default: 0};
   int rd_cnt [N] = '{default: 0};
   int onehot_errs = 0, data_errs = 0, lastpos_errs = 0;
   int burst_n = 0;
   int port_arr [64] = '{default: 0};
   int burst_arr [64] = '{default: 0};
   int between_arr [64] = '{default: 0};
   int gap_meas = 0, rd_rise_cyc = 0, dv_rise_cyc = 0;
   int cur_burst = 0, low_run = 0, post_cnt = 0;
   logic prev_dv = 1'b0, prev_last = 1'b0, prev_busy = 1'b0, prev_rd = 1'b0;

   always @(negedge iclk) begin
      logic [N-1:0] sel;
      sel = N'(1) << otx_port;
      for (int k = 0; k < N; k++) begin
         pop_cnt[k] += int'(olen_pop[k]);
         rd_cnt[k]  += int'(ord_en[k]);
      end
      if ($countones(ord_en) > 1 || $countones(olen_pop) > 1) onehot_errs++;
      if (((ord_en | olen_pop) & ~sel) != '0) onehot_errs++;
      if (ord_en != '0 && !prev_rd) rd_rise_cyc = cyc;
      err_cnt  += int'(olen_err);
      last_cnt += int'(otx_last);
      if (otx_last && !otx_dv) lastpos_errs++;
      if (otx_dv) begin
         dv_cnt++;
         if (otx_d !== byte_of(int'(otx_port), data_addr[otx_port])) data_errs++;
         if (!prev_dv) begin
            dv_rise_cyc = cyc;
            if (burst_n < 64) begin
               port_arr[burst_n]    = int'(otx_port);
               between_arr[burst_n] = low_run;
            end
            cur_burst = 0;
         end
         cur_burst++;
         low_run  = 0;
         post_cnt = 0;
      end else begin
         if (prev_dv) begin
            if (!prev_last) lastpos_errs++;
            if (burst_n < 64) burst_arr[burst_n] = cur_burst;
            burst_n++;
         end
         low_run++;
         if (obusy) post_cnt++;
         else begin
            if (prev_busy) gap_meas = post_cnt;
            post_cnt = 0;
         end
      end
      prev_dv   = otx_dv;
      prev_last = otx_last;
      prev_busy = obusy;
      prev_rd   = (ord_en != '0);
   end

   // Scoreboard and check helpers
   int checks = 0;
   int errors = 0;
   logic [PW-1:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_grants(input string tag, input int first);
      int idx;
      idx = first;
      while (exp_q.size() > 0) begin
         check(tag, 32'(port_arr[idx]), 32'(exp_q.pop_front()));
         idx++;
      end
   endtask

   // Driver tasks
   task automatic load(input int k, input int len);
      len_mem[k][wr_idx[k] % 16] = LW'(len);
      wr_idx[k]++;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      while (!obusy && n < 20) begin
         @(negedge iclk);
         n++;
      end
      n = 0;
      while (obusy && n < budget) begin
         @(negedge iclk);
         n++;
      end
      #1;
      check(tag, 32'(obusy), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge iclk);
      i_rst = 1'b1;
      repeat (2) @(negedge iclk);
      i_rst = 1'b0;
   endtask

   // Snapshot of monitor counters taken at the start of each step
   int b_dv, b_last, b_err, b_oh, b_data, b_lp, b_burst;
   int b_pop [N];
   int b_rd [N];

   task automatic snap();
      b_dv = dv_cnt; b_last = last_cnt; b_err = err_cnt; b_oh = onehot_errs;
      b_data = data_errs; b_lp = lastpos_errs; b_burst = burst_n;
      for (int k = 0; k < N; k++) begin
         b_pop[k] = pop_cnt[k];
         b_rd[k]  = rd_cnt[k];
      end
   endtask

   initial begin
      int t;
      // Reset state
      repeat (3) @(negedge iclk);
      check("rst_busy", 32'(obusy), 32'd0);
      check("rst_dv", 32'(otx_dv), 32'd0);
      check("rst_last", 32'(otx_last), 32'd0);
      check("rst_d", 32'(otx_d), 32'd0);
      check("rst_pop", 32'(olen_pop), 32'd0);
      check("rst_rd", 32'(ord_en), 32'd0);
      check("rst_port", 32'(otx_port), 32'd0);
      check("rst_err", 32'(olen_err), 32'd0);
      check("rst_state", 32'(odbg_state), 32'd0);
      i_rst = 1'b0;
      repeat (2) @(negedge iclk);
      check("idle_busy", 32'(obusy), 32'd0);

      // Single packet of 64 bytes on port 1
      snap();
      load(1, 64);
      @(negedge iclk);
      check("sp_state_grant", 32'(odbg_state), 32'd1);
      check("sp_pop_vec", 32'(olen_pop), 32'b0010);
      check("sp_port", 32'(otx_port), 32'd1);
      wait_idle("sp_timeout", 200);
      check("sp_pop", 32'(pop_cnt[1] - b_pop[1]), 32'd1);
      check("sp_rd", 32'(rd_cnt[1] - b_rd[1]), 32'd64);
      check("sp_dv", 32'(dv_cnt - b_dv), 32'd64);
      check("sp_burst_len", 32'(burst_arr[b_burst]), 32'd64);
      check("sp_last", 32'(last_cnt - b_last), 32'd1);
      check("sp_burst_port", 32'(port_arr[b_burst]), 32'd1);
      check("sp_latency", 32'(dv_rise_cyc - rd_rise_cyc), 32'd1);
      check("sp_gap", 32'(gap_meas), 32'(IFG));
      check("sp_err", 32'(err_cnt - b_err), 32'd0);
      check("sp_data", 32'(data_errs - b_data), 32'd0);

      // Round-robin: four ports with two 64-byte packets each, from reset
      do_reset();
      snap();
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < N; k++) begin
            load(k, 64);
            exp_q.push_back(PW'(k));
         end
      end
      for (int p = 0; p < 8; p++) wait_idle("rr_timeout", 300);
      check_grants("rr_grant", b_burst);
      for (int b = 0; b < 8; b++) check("rr_burst_len", 32'(burst_arr[b_burst + b]), 32'd64);
      // dv-low run between bursts: IFG gap cycles plus IDLE, GRANT and the first READ cycle
      for (int b = 1; b < 8; b++) check("rr_between", 32'(between_arr[b_burst + b]), 32'(IFG + 3));
      check("rr_last", 32'(last_cnt - b_last), 32'd8);
      check("rr_data", 32'(data_errs - b_data), 32'd0);

      // Illegal length 40 on port 2: read out but not transmitted
      snap();
      load(2, 40);
      wait_idle("ill40_timeout", 200);
      check("ill40_err", 32'(err_cnt - b_err), 32'd1);
      check("ill40_pop", 32'(pop_cnt[2] - b_pop[2]), 32'd1);
      check("ill40_rd", 32'(rd_cnt[2] - b_rd[2]), 32'd40);
      check("ill40_dv", 32'(dv_cnt - b_dv), 32'd0);
      check("ill40_busy", 32'(gap_meas), 32'(40 + IFG + 2));

      // Zero length: no reads at all
      snap();
      load(2, 0);
      wait_idle("zero_timeout", 100);
      check("zero_err", 32'(err_cnt - b_err), 32'd1);
      check("zero_pop", 32'(pop_cnt[2] - b_pop[2]), 32'd1);
      check("zero_rd", 32'(rd_cnt[2] - b_rd[2]), 32'd0);
      check("zero_busy", 32'(gap_meas), 32'(IFG + 1));

      // Maximum legal length
      snap();
      load(0, 1536);
      wait_idle("max_timeout", 2000);
      check("max_dv", 32'(dv_cnt - b_dv), 32'd1536);
      check("max_burst", 32'(burst_arr[b_burst]), 32'd1536);
      check("max_bursts", 32'(burst_n - b_burst), 32'd1);
      check("max_last", 32'(last_cnt - b_last), 32'd1);
      check("max_data", 32'(data_errs - b_data), 32'd0);
      check("max_err", 32'(err_cnt - b_err), 32'd0);

      // One byte over the maximum is discarded
      snap();
      load(0, 1537);
      wait_idle("ovr_timeout", 2000);
      check("ovr_err", 32'(err_cnt - b_err), 32'd1);
      check("ovr_rd", 32'(rd_cnt[0] - b_rd[0]), 32'd1537);
      check("ovr_dv", 32'(dv_cnt - b_dv), 32'd0);
      check("oh_before_rst", 32'(onehot_errs), 32'd0);
      check("lastpos_before_rst", 32'(lastpos_errs), 32'd0);

      // Reset at byte 100 of a 200-byte packet
      snap();
      load(0, 200);
      t = 0;
      while ((dv_cnt - b_dv) < 100 && t < 300) begin
         @(negedge iclk);
         #1;
         t++;
      end
      check("mid_reached_100", 32'(dv_cnt - b_dv), 32'd100);
      #2;
      i_rst = 1'b1;
      #1;
      check("mid_rst_dv", 32'(otx_dv), 32'd0);
      check("mid_rst_rd", 32'(ord_en), 32'd0);
      check("mid_rst_busy", 32'(obusy), 32'd0);
      repeat (2) @(negedge iclk);
      i_rst = 1'b0;
      snap();
      load(3, 64);
      load(0, 64);
      exp_q.push_back(PW'(0));
      exp_q.push_back(PW'(3));
      wait_idle("post_rst_timeout1", 300);
      wait_idle("post_rst_timeout2", 300);
      check_grants("post_rst_grant", b_burst);
      check("post_rst_last", 32'(last_cnt - b_last), 32'd2);
      check("post_rst_data", 32'(data_errs - b_data), 32'd0);
      check("oh_total", 32'(onehot_errs), 32'd0);

`ifdef PKT_EGRESS_STATS_EN
      // Statistics: five legal and two illegal packets after a reset
      do_reset();
      check("stats_rst_pkt", otx_pkt_cnt, 32'd0);
      check("stats_rst_drop", 32'(odrop_cnt), 32'd0);
      load(0, 64); load(0, 64); load(0, 40);
      load(1, 64); load(1, 0);  load(1, 64);
      load(2, 64);
      for (int p = 0; p < 7; p++) wait_idle("stats_timeout", 300);
      check("stats_pkt", otx_pkt_cnt, 32'd5);
      check("stats_drop", 32'(odrop_cnt), 32'd2);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Absolute time bound
   initial begin
      #2000000;
      $display("FAIL global_timeout: observed simulation still running, expected completion");
      $fatal(1, "timeout");
   end
endmodule
